// File: rtl/arbiter_pkg.sv
// Shared definitions for the arbiter write-back path.
//  - DATA_W / ORDER_W : result and order-tag widths
//  - FIFO_DEPTH       : default number of buffered results
//  - ORDER_NOP        : order tag meaning "accept and discard"
//  - REG0..REG3       : register-file index constants
//  - wb_state_t       : write-back FSM encoding
//  - wb_entry_t       : one buffered result {order, dest, data}
//  - is_operand_dest  : true for the registers read by the arbiter
package arbiter_pkg;

  localparam int DATA_W     = 8;
  localparam int ORDER_W    = 3;
  localparam int FIFO_DEPTH = 2;

  localparam logic [ORDER_W-1:0] ORDER_NOP = 3'b111;

  localparam logic [1:0] REG0 = 2'd0;
  localparam logic [1:0] REG1 = 2'd1;
  localparam logic [1:0] REG2 = 2'd2;
  localparam logic [1:0] REG3 = 2'd3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CHECK  = 2'd1,
    HOLD   = 2'd2,
    COMMIT = 2'd3
  } wb_state_t;

  typedef struct packed {
    logic [ORDER_W-1:0] order;
    logic [1:0]         dest;
    logic [DATA_W-1:0]  data;
  } wb_entry_t;

  // reg_0 and reg_3 feed the arbiter read ports, so writes to them must wait
  // while the arbiter is selecting.
  function automatic logic is_operand_dest(input logic [1:0] dest);
    return (dest == REG0) || (dest == REG3);
  endfunction

endpackage

// File: rtl/arbiter_writeback_if.sv
// Result handshake between a producer and the write-back block.
//  wb_valid  producer has a result
//  wb_ready  write-back can accept (transfer on wb_valid && wb_ready)
//  wb_data   result value
//  wb_dest   destination register index 0..3
//  wb_order  order tag; ORDER_NOP means accept and discard
// master = producer side, slave = write-back side.
interface arbiter_writeback_if;
  import arbiter_pkg::*;

  logic                wb_valid;
  logic                wb_ready;
  logic [DATA_W-1:0]   wb_data;
  logic [1:0]          wb_dest;
  logic [ORDER_W-1:0]  wb_order;

  modport master (
    output wb_valid, wb_data, wb_dest, wb_order,
    input  wb_ready
  );

  modport slave (
    input  wb_valid, wb_data, wb_dest, wb_order,
    output wb_ready
  );

endinterface

// File: rtl/wb_fifo.sv
// Small synchronous FIFO of write-back entries.
//  clk, rst_n   clock, asynchronous active-low reset
//  push         write push_entry (ignored when full)
//  push_entry   entry to store
//  pop          drop the head entry (ignored when empty)
//  head         current oldest entry
//  full, empty  occupancy flags from the registered count
//  count        number of stored entries
module wb_fifo
  import arbiter_pkg::*;
#(
  parameter int  DEPTH = FIFO_DEPTH,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  wb_entry_t        push_entry,
  input  logic             pop,
  output wb_entry_t        head,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  wb_entry_t        mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [CNT_W-1:0] count_r;
  logic             do_push_s;
  logic             do_pop_s;

  assign full      = (count_r == CNT_W'(DEPTH));
  assign empty     = (count_r == CNT_W'(0));
  assign count     = count_r;
  assign head      = mem_r[rd_ptr_r];
  assign do_push_s = push && !full;
  assign do_pop_s  = pop && !empty;

  // Storage, pointers (wrap modulo DEPTH) and occupancy count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= PTR_W'(0);
      rd_ptr_r <= PTR_W'(0);
      count_r  <= CNT_W'(0);
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
    end else begin
      if (do_push_s) begin
        mem_r[wr_ptr_r] <= push_entry;
        wr_ptr_r        <= wr_ptr_r + PTR_W'(1);
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/arbiter_writeback.sv
// Write-back stage: buffers results from the handshake and commits them, in
// acceptance order, into a 4-entry register file. Commits to reg_0/reg_3 wait
// while arbiter_sel is high so the arbiter's operands stay stable.
//  clk, rst_n    clock, asynchronous active-low reset (released synchronously
//                by the reset source)
//  wb            result handshake (slave side)
//  arbiter_sel   arbiter read in progress
//  reg_0..reg_3  register file contents
//  wb_done       one-cycle pulse per commit or discard
//  wb_busy       FIFO non-empty or FSM not idle
module arbiter_writeback
  import arbiter_pkg::*;
#(
  parameter int DEPTH = FIFO_DEPTH
) (
  input  logic                clk,
  input  logic                rst_n,
  arbiter_writeback_if.slave  wb,
  input  logic                arbiter_sel,
  output logic [DATA_W-1:0]   reg_0,
  output logic [DATA_W-1:0]   reg_1,
  output logic [DATA_W-1:0]   reg_2,
  output logic [DATA_W-1:0]   reg_3,
  output logic                wb_done,
  output logic                wb_busy
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  wb_state_t          state_r;
  logic [DATA_W-1:0]  reg_file_r [4];
  logic               wb_done_r;

  wb_entry_t          push_entry_s;
  wb_entry_t          head_s;
  logic               fifo_full_s;
  logic               fifo_empty_s;
  logic [CNT_W-1:0]   fifo_count_s;
  logic               push_s;
  logic               pop_s;
  logic               commit_s;
  logic               head_is_nop_s;

  // Ready depends only on the registered count, never on wb_valid.
  assign wb.wb_ready   = !fifo_full_s;
  assign push_s        = wb.wb_valid && !fifo_full_s;
  assign push_entry_s  = '{order: wb.wb_order, dest: wb.wb_dest, data: wb.wb_data};
  assign head_is_nop_s = (head_s.order == ORDER_NOP);

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (push_s),
    .push_entry (push_entry_s),
    .pop        (pop_s),
    .head       (head_s),
    .full       (fifo_full_s),
    .empty      (fifo_empty_s),
    .count      (fifo_count_s)
  );

  // Decide whether the head leaves the FIFO this cycle. The register write
  // lands on the edge that enters COMMIT, which gives the two-edge
  // accept-to-update latency; COMMIT itself only picks the next state.
  always_comb begin
    pop_s    = 1'b0;
    commit_s = 1'b0;
    case (state_r)
      CHECK: begin
        if (head_is_nop_s) begin
          pop_s = 1'b1;
        end else if (is_operand_dest(head_s.dest) && arbiter_sel) begin
          pop_s = 1'b0;
        end else begin
          pop_s    = 1'b1;
          commit_s = 1'b1;
        end
      end
      HOLD: begin
        if (!arbiter_sel) begin
          pop_s    = 1'b1;
          commit_s = 1'b1;
        end else begin
          pop_s    = 1'b0;
        end
      end
      default: begin
        pop_s    = 1'b0;
        commit_s = 1'b0;
      end
    endcase
  end

  // Write-back FSM, register file and done pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= IDLE;
      wb_done_r <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        reg_file_r[i] <= DATA_W'(0);
      end
    end else begin
      // Every pop is exactly one commit or one discard.
      wb_done_r <= pop_s;
      if (commit_s) begin
        reg_file_r[head_s.dest] <= head_s.data;
      end
      case (state_r)
        IDLE: begin
          state_r <= fifo_empty_s ? IDLE : CHECK;
        end
        CHECK: begin
          if (head_is_nop_s) begin
            // Another entry remains after this pop, or one arrives now.
            state_r <= ((fifo_count_s > CNT_W'(1)) || push_s) ? CHECK : IDLE;
          end else if (commit_s) begin
            state_r <= COMMIT;
          end else begin
            state_r <= HOLD;
          end
        end
        HOLD: begin
          state_r <= commit_s ? COMMIT : HOLD;
        end
        COMMIT: begin
          state_r <= (!fifo_empty_s || push_s) ? CHECK : IDLE;
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign reg_0   = reg_file_r[0];
  assign reg_1   = reg_file_r[1];
  assign reg_2   = reg_file_r[2];
  assign reg_3   = reg_file_r[3];
  assign wb_done = wb_done_r;
  assign wb_busy = !fifo_empty_s || (state_r != IDLE);

endmodule

// File: tb/tb_arbiter_writeback.sv
// Self-checking bench for arbiter_writeback: directed pushes with literal
// expectations plus a queue-based reference of accepted results compared on
// every clock.
module tb_arbiter_writeback;
  import arbiter_pkg::*;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              arbiter_sel = 1'b0;
  logic [DATA_W-1:0] reg_0, reg_1, reg_2, reg_3;
  logic              wb_done, wb_busy;

  int checks = 0;
  int errors = 0;

  arbiter_writeback_if bus ();

  arbiter_writeback #(.DEPTH(2)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .wb          (bus.slave),
    .arbiter_sel (arbiter_sel),
    .reg_0       (reg_0),
    .reg_1       (reg_1),
    .reg_2       (reg_2),
    .reg_3       (reg_3),
    .wb_done     (wb_done),
    .wb_busy     (wb_busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Accepted-but-unfinished results in acceptance order; each wb_done retires
  // the oldest one. Registers hold the last committed value per destination.
  wb_entry_t         model_q[$];
  logic [DATA_W-1:0] mreg [4];
  bit                last_commit;

  initial begin
    wb_entry_t pre_ent;
    wb_entry_t e;
    logic      pre_acc, pre_sel, pre_rst;
    for (int i = 0; i < 4; i++) mreg[i] = '0;
    last_commit = 1'b0;
    forever begin
      @(posedge clk);
      pre_rst       = rst_n;
      pre_acc       = rst_n && bus.wb_valid && bus.wb_ready;
      pre_sel       = arbiter_sel;
      pre_ent.order = bus.wb_order;
      pre_ent.dest  = bus.wb_dest;
      pre_ent.data  = bus.wb_data;
      #1;
      if (!pre_rst || !rst_n) begin
        model_q.delete();
        for (int i = 0; i < 4; i++) mreg[i] = '0;
        last_commit = 1'b0;
      end else begin
        last_commit = 1'b0;
        check("done_has_entry", 32'(wb_done && (model_q.size() == 0)), 32'd0);
        if (wb_done && model_q.size() > 0) begin
          e = model_q.pop_front();
          if (e.order != ORDER_NOP) begin
            check("operand_write_during_sel", 32'(is_operand_dest(e.dest) && pre_sel), 32'd0);
            mreg[e.dest] = e.data;
            last_commit  = 1'b1;
          end
        end
        if (pre_acc) model_q.push_back(pre_ent);
        check("m_reg_0", 32'(reg_0), 32'(mreg[0]));
        check("m_reg_1", 32'(reg_1), 32'(mreg[1]));
        check("m_reg_2", 32'(reg_2), 32'(mreg[2]));
        check("m_reg_3", 32'(reg_3), 32'(mreg[3]));
        check("m_ready", 32'(bus.wb_ready), 32'(model_q.size() < 2));
        check("m_busy",  32'(wb_busy), 32'((model_q.size() > 0) || last_commit));
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] dest, input logic [7:0] data, input logic [2:0] order);
    bus.wb_valid = 1'b1;
    bus.wb_dest  = dest;
    bus.wb_data  = data;
    bus.wb_order = order;
  endtask

  // Holds valid until accepted, randomising arbiter_sel each cycle.
  task automatic push_wait(input logic [1:0] dest, input logic [7:0] data,
                           input logic [2:0] order, input int max_cyc);
    bit accepted = 1'b0;
    drive(dest, data, order);
    for (int i = 0; i < max_cyc && !accepted; i++) begin
      if (bus.wb_ready) accepted = 1'b1;
      arbiter_sel = 1'($urandom_range(0, 1));
      step();
    end
    bus.wb_valid = 1'b0;
    check("push_accepted", 32'(accepted), 32'd1);
  endtask

  task automatic wait_idle(input int max_cyc);
    for (int i = 0; i < max_cyc && wb_busy; i++) step();
    check("drain_idle", 32'(wb_busy), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  // ---------------- directed tests ----------------
  initial begin
    bus.wb_valid = 1'b0;
    bus.wb_data  = 8'h00;
    bus.wb_dest  = 2'd0;
    bus.wb_order = 3'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // Reset state
    check("rst_reg_0", 32'(reg_0), 32'h0);
    check("rst_reg_3", 32'(reg_3), 32'h0);
    check("rst_ready", 32'(bus.wb_ready), 32'd1);
    check("rst_busy",  32'(wb_busy), 32'd0);
    check("rst_done",  32'(wb_done), 32'd0);

    // Unblocked commit: register updates two edges after accept
    drive(2'd0, 8'hF0, 3'd0);
    step();
    bus.wb_valid = 1'b0;
    check("t2_reg0_e0", 32'(reg_0), 32'h0);
    check("t2_busy_e0", 32'(wb_busy), 32'd1);
    step();
    check("t2_reg0_e1", 32'(reg_0), 32'h0);
    check("t2_done_e1", 32'(wb_done), 32'd0);
    step();
    check("t2_reg0_e2", 32'(reg_0), 32'hF0);
    check("t2_done_e2", 32'(wb_done), 32'd1);
    step();
    check("t2_done_e3", 32'(wb_done), 32'd0);
    check("t2_busy_e3", 32'(wb_busy), 32'd0);

    // Operand commit held while arbiter_sel is high
    arbiter_sel = 1'b1;
    drive(2'd3, 8'h01, 3'd0);
    step();
    bus.wb_valid = 1'b0;
    repeat (4) step();
    check("t3_reg3_held", 32'(reg_3), 32'h0);
    check("t3_busy_held", 32'(wb_busy), 32'd1);
    check("t3_done_held", 32'(wb_done), 32'd0);
    arbiter_sel = 1'b0;
    step();
    check("t3_reg3_rel", 32'(reg_3), 32'h01);
    check("t3_done_rel", 32'(wb_done), 32'd1);
    step();

    // Held head blocks a younger dest-1 entry; FIFO fills
    arbiter_sel = 1'b1;
    drive(2'd3, 8'h22, 3'd1);
    step();
    drive(2'd1, 8'hAA, 3'd2);
    step();
    check("t4_full", 32'(bus.wb_ready), 32'd0);
    drive(2'd2, 8'h77, 3'd3);
    repeat (2) step();
    check("t4_full_hold", 32'(bus.wb_ready), 32'd0);
    check("t4_reg1_blocked", 32'(reg_1), 32'h0);
    check("t4_reg3_old", 32'(reg_3), 32'h01);
    arbiter_sel = 1'b0;
    step();
    check("t4_reg3_new", 32'(reg_3), 32'h22);
    check("t4_reg1_after3", 32'(reg_1), 32'h0);
    check("t4_done", 32'(wb_done), 32'd1);
    step();
    bus.wb_valid = 1'b0;
    check("t4_third_in", 32'(bus.wb_ready), 32'd0);
    step();
    check("t4_reg1", 32'(reg_1), 32'hAA);
    wait_idle(20);
    check("t4_reg2", 32'(reg_2), 32'h77);

    // Reset mid-operation: asynchronous, pending entry dropped
    drive(2'd0, 8'h99, 3'd0);
    step();
    bus.wb_valid = 1'b0;
    #3;
    rst_n = 1'b0;
    #1;
    check("t1_reg_0", 32'(reg_0), 32'h0);
    check("t1_reg_1", 32'(reg_1), 32'h0);
    check("t1_reg_2", 32'(reg_2), 32'h0);
    check("t1_reg_3", 32'(reg_3), 32'h0);
    check("t1_ready", 32'(bus.wb_ready), 32'd1);
    check("t1_busy",  32'(wb_busy), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) step();
    check("t1_dropped", 32'(reg_0), 32'h0);
    check("t1_idle", 32'(wb_busy), 32'd0);

    // NOP: discarded with a done pulse, no write
    drive(2'd2, 8'h55, ORDER_NOP);
    step();
    bus.wb_valid = 1'b0;
    step();
    check("t5_done_e1", 32'(wb_done), 32'd0);
    step();
    check("t5_done_e2", 32'(wb_done), 32'd1);
    check("t5_reg2", 32'(reg_2), 32'h0);
    step();
    check("t5_done_e3", 32'(wb_done), 32'd0);
    check("t5_busy", 32'(wb_busy), 32'd0);

    // Streaming four results with random arbiter_sel
    for (int k = 0; k < 4; k++) begin
      push_wait(2'(k), 8'(17 * (k + 1)), 3'(k), 60);
    end
    arbiter_sel = 1'b0;
    wait_idle(60);
    check("t6_reg_0", 32'(reg_0), 32'h11);
    check("t6_reg_1", 32'(reg_1), 32'h22);
    check("t6_reg_2", 32'(reg_2), 32'h33);
    check("t6_reg_3", 32'(reg_3), 32'h44);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
